// File: rtl/alu_cmd_sequencer.sv
// Purpose: valid/ready command front-end for the combinational 4-bit ALU, with flag checking and saturating stats.
// Latency: accept at edge k, ALU sampled at edge k+SETTLE_CYCLES, response valid right after it; one op in flight.
// Backpressure: cmd_ready only in IDLE; response held frozen while rsp_ready is low, with no timeout.
module alu_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 1,  // legal range 1..15
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [3:0]       alu_result,
  input  logic             alu_carry_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [2:0]       rsp_op,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] zero_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Counter runs SETTLE_CYCLES-1 down to 0, so sampling lands exactly SETTLE_CYCLES edges after accept.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state_q;
  state_t     state_d;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       sample;
  logic       rsp_fire;
  logic       carry_meaningful;

  // Handshake outputs come straight from the state register, never from inputs.
  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  // Carry only means something for ADD (000) and SUB (001).
  assign carry_meaningful = (alu_ctrl[2:1] == 2'b00);

  // Next-state decode plus single-cycle strobes that steer the datapath registers.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    sample   = 1'b0;
    rsp_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          sample  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Settle countdown: loaded on accept, decremented while waiting for the ALU to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= 4'd0;
    end else if (accept) begin
      settle_cnt <= SETTLE_LOAD;
    end else if (state_q == SETTLE && settle_cnt != 4'd0) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  // ALU drive registers change only on an accept edge, so the ALU inputs stay quiet while settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= 4'd0;
      alu_b    <= 4'd0;
      alu_ctrl <= 3'd0;
    end else if (accept) begin
      alu_a    <= cmd_a;
      alu_b    <= cmd_b;
      alu_ctrl <= cmd_op;
    end
  end

  // Capture the settled ALU outputs and the flag-consistency check in one shot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= 4'd0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_op     <= 3'd0;
      rsp_err    <= 1'b0;
    end else if (sample) begin
      rsp_result <= alu_result;
      rsp_carry  <= carry_meaningful ? alu_carry_out : 1'b0;
      rsp_zero   <= alu_zero;
      rsp_op     <= alu_ctrl;
      rsp_err    <= (alu_zero != (alu_result == 4'd0));
    end
  end

  // Statistics bump on the response handshake and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count   <= '0;
      zero_count <= '0;
    end else if (rsp_fire) begin
      if (op_count != CNT_MAX) begin
        op_count <= op_count + CNT_W'(1);
      end
      if (rsp_zero && zero_count != CNT_MAX) begin
        zero_count <= zero_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Clocked command front-end for the combinational 4-bit ALU. It accepts operand/opcode commands over a valid/ready stream and drives them onto the ALU inputs. After a programmable settle time it samples the ALU result and flags, then returns them over a valid/ready response stream. It also checks flag consistency and keeps saturating operation statistics, and sits between any command source (CPU datapath, bench driver, scan sequencer) and the `alu` instance.

## Interface
- `SETTLE_CYCLES`, default 1: clock edges between driving ALU inputs and sampling ALU outputs; legal range 1..15.
- `CNT_W`, default 16: width of the statistics counters.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_a`, `cmd_b`  in  4 each  operands.
- `cmd_op`  in  3  ALU opcode; same encoding as `alu_ctrl`, 000 ADD … 111 PASS-A.
- `alu_a`, `alu_b`  out  4 each  registered drive to ALU `a`/`b`.
- `alu_ctrl`  out  3  registered drive to ALU `alu_ctrl`.
- `alu_result`  in  4  from ALU `result`.
- `alu_carry_out`  in  1  from ALU `carry_out`.
- `alu_zero`  in  1  from ALU `zero`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_result`  out  4  sampled result.
- `rsp_carry`  out  1  sampled carry; meaningful for ADD/SUB only.
- `rsp_zero`  out  1  sampled zero flag.
- `rsp_op`  out  3  opcode of this response.
- `rsp_err`  out  1  flag-consistency error for this response.
- `op_count`  out  `CNT_W`  completed responses, saturating.
- `zero_count`  out  `CNT_W`  completed responses with `rsp_zero`=1, saturating.

## Operation
- FSM states: IDLE, SETTLE, RESP. `cmd_ready` = (state==IDLE); `rsp_valid` = (state==RESP). Both are decoded from state registers, not from inputs.
- IDLE, when `cmd_valid`=1:
  - Register `cmd_a`/`cmd_b`/`cmd_op` into `alu_a`/`alu_b`/`alu_ctrl`.
  - Load the settle counter with `SETTLE_CYCLES`-1.
  - Go to SETTLE.
- SETTLE:
  - If counter≠0, decrement.
  - If counter==0, sample the ALU outputs into the `rsp_*` registers and go to RESP.
- Sampling rules:
  - `rsp_result` = `alu_result`.
  - `rsp_zero` = `alu_zero`.
  - `rsp_carry` = `alu_carry_out` when `alu_ctrl` is 000 or 001, else 0.
  - `rsp_op` = `alu_ctrl`.
  - `rsp_err` = (`alu_zero` != (`alu_result`==4'd0)).
- RESP: hold all `rsp_*` stable until `rsp_valid`&&`rsp_ready`. At that edge:
  - `op_count`+=1.
  - `zero_count`+=1 if `rsp_zero`.
  - Go to IDLE.
  - Counters saturate at all-ones and never wrap.
- `alu_a`/`alu_b`/`alu_ctrl` hold their last values outside IDLE-accept edges; the ALU inputs never glitch during SETTLE or RESP.
- Commands presented while not in IDLE are not accepted (`cmd_ready`=0). The source must hold them.
- No command overlap, no internal queue: one command in flight at a time.
- Reset, asynchronous, at any time including mid-SETTLE or RESP:
  - State→IDLE; any in-flight command is discarded with no response.
  - All outputs go to 0, except `cmd_ready`=1.
  - Counters go to 0.

## Timing
- Command accepted at edge k. ALU inputs update after edge k. Sampling occurs at edge k+`SETTLE_CYCLES`. `rsp_valid` is high from just after edge k+`SETTLE_CYCLES`.
- With `rsp_ready` held high:
  - Response handshake at edge k+`SETTLE_CYCLES`+1.
  - `cmd_ready` high after that edge.
  - Next accept no earlier than edge k+`SETTLE_CYCLES`+2.
  - Maximum throughput is one op per `SETTLE_CYCLES`+2 cycles.
- `rsp_ready` low: RESP held indefinitely with outputs frozen; no timeout.
- Counters update on the handshake edge and are visible the following cycle.

## Test plan
- ADD: `cmd_a`=9, `cmd_b`=8, op 000, `SETTLE_CYCLES`=1, `rsp_ready`=1 → `rsp_valid` one cycle after accept, `rsp_result`=1, `rsp_carry`=1, `rsp_zero`=0, `rsp_err`=0; `cmd_ready` returns 2 cycles after accept.
- SUB: 5−5 (op 001) → `rsp_result`=0, `rsp_zero`=1, `rsp_carry`=0; then 3−5 → `rsp_result`=14, `rsp_carry`=1. Afterwards `op_count`=2, `zero_count`=1.
- Backpressure and busy: hold `rsp_ready`=0 for 4 cycles with XOR 12^10 → `rsp_result`=6 stable all 4 cycles. A second `cmd_valid` in this window is not accepted, and `alu_a`/`alu_b` do not change. The second command is accepted only after the handshake.
- Flag error: ALU model forced to `alu_result`=3, `alu_zero`=1 → `rsp_err`=1. For op 010 (AND) with the carry input forced to 1 → `rsp_carry`=0.
- Saturation: `CNT_W`=2, 5 back-to-back ops with result 0 → `op_count`=3 and `zero_count`=3, with no wrap to 0.
- Reset mid-op: `SETTLE_CYCLES`=4, assert `rst_n`=0 two cycles after accept, without waiting for an edge → immediately `cmd_ready`=1, `rsp_valid`=0, counters=0, `alu_*`=0. No response is ever produced for the aborted command.
